// File: rtl/lm_sm_sequencer_if.sv
// Decode-stage interface between the instruction in ID and the LM/SM
// sequencer: instruction fields and pipeline controls in, micro-op out.
interface lm_sm_sequencer_if #(
  parameter int DATA_W = 16
) ();
  logic              inst_valid;
  logic [3:0]        opcode;
  logic [7:0]        reg_list;
  logic              stall_in;
  logic              flush;
  logic              seq_hold;
  logic              busy;
  logic              uop_valid;
  logic              uop_is_load;
  logic [2:0]        uop_reg;
  logic [DATA_W-1:0] uop_offset;
  logic              uop_last;

  // Decode side: presents the instruction, consumes the micro-op stream.
  modport master (
    output inst_valid, opcode, reg_list, stall_in, flush,
    input  seq_hold, busy, uop_valid, uop_is_load, uop_reg, uop_offset, uop_last
  );

  // Sequencer side.
  modport slave (
    input  inst_valid, opcode, reg_list, stall_in, flush,
    output seq_hold, busy, uop_valid, uop_is_load, uop_reg, uop_offset, uop_last
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: breaks a multi-register load/store into one register
// transfer per cycle, lowest register first. The first transfer issues
// straight from IDLE with zero latency; IF/ID and PC are held until the
// last transfer issues.
module lm_sm_sequencer #(
  parameter logic [3:0] OPC_LM = 4'b0110,
  parameter logic [3:0] OPC_SM = 4'b0111,
  parameter int         DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  lm_sm_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_reg, state_next;
  logic [7:0] mask_reg, mask_next;
  logic [2:0] count_reg, count_next;
  logic       is_load_reg, is_load_next;

  logic       is_lmsm;
  logic       start;
  logic [7:0] cur_mask;
  logic       cur_load;
  logic       active;
  logic [7:0] onehot;
  logic [7:0] rem;
  logic [2:0] reg_idx;
  logic       valid_int;

  // Decode the instruction and pick the current transfer from the live
  // register list (IDLE) or the remaining mask (RUN).
  always_comb begin
    is_lmsm  = (bus.opcode == OPC_LM) || (bus.opcode == OPC_SM);
    start    = bus.inst_valid && is_lmsm && (state_reg == IDLE);
    cur_mask = (state_reg == IDLE) ? bus.reg_list : mask_reg;
    cur_load = (state_reg == IDLE) ? (bus.opcode == OPC_LM) : is_load_reg;
    active   = (start && (bus.reg_list != 8'd0)) || (state_reg == RUN);
    onehot   = cur_mask & (~cur_mask + 8'd1);
    rem      = cur_mask & ~onehot;
    reg_idx  = 3'd0;
    // Descending scan so the lowest set bit is the one that sticks.
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) reg_idx = 3'(i);
    end
  end

  // Micro-op outputs; everything is forced low while reset is asserted.
  always_comb begin
    valid_int       = !reset && active && !bus.flush;
    bus.uop_valid   = valid_int;
    bus.uop_reg     = valid_int ? reg_idx : 3'd0;
    bus.uop_is_load = valid_int && cur_load;
    bus.uop_offset  = (valid_int && state_reg == RUN) ?
                      {{(DATA_W-3){1'b0}}, count_reg} : {DATA_W{1'b0}};
    bus.uop_last    = valid_int && (rem == 8'd0);
    bus.busy        = !reset && (state_reg == RUN);
    bus.seq_hold    = valid_int && ((rem != 8'd0) || bus.stall_in);
  end

  // Next-state: flush beats stall, stall beats advance.
  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    count_next   = count_reg;
    is_load_next = is_load_reg;
    if (bus.flush) begin
      state_next = IDLE;
      mask_next  = 8'd0;
      count_next = 3'd0;
    end else if (active && bus.stall_in) begin
      // Hold everything; the same micro-op is re-presented.
    end else if (active && rem != 8'd0) begin
      state_next   = RUN;
      mask_next    = rem;
      count_next   = ((state_reg == IDLE) ? 3'd0 : count_reg) + 3'd1;
      is_load_next = cur_load;
    end else if (active) begin
      // Last transfer: ID advances on this edge, so IDLE sees a new instruction.
      state_next = IDLE;
      mask_next  = 8'd0;
      count_next = 3'd0;
    end
  end

  // State registers with asynchronous reset that discards any open sequence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      mask_reg    <= 8'd0;
      count_reg   <= 3'd0;
      is_load_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      count_reg   <= count_next;
      is_load_reg <= is_load_next;
    end
  end

endmodule
